// File: rtl/trng_word_arbiter_pkg.sv
// Shared types and helpers for the TRNG word arbiter: FSM state encoding,
// default sizes and the round-robin pick function.
package trng_pkg;

  localparam int DEF_WORD_W      = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    GRANT,
    WAIT_RDY,
    ACK_HI,
    DONE
  } trng_arb_state_t;

  // One-hot pick of the first requester above 'last' (with wrap) among n.
  // Walks the candidates backwards so the nearest one wins the last write.
  function automatic logic [3:0] rr_next(input logic [3:0] req, input logic [1:0] last,
                                         input int n);
    logic [3:0] g;
    int         idx;
    g = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = (int'(last) + k) % n;
      if (k <= n && req[idx[1:0]]) g = 4'b0001 << idx[1:0];
    end
    return g;
  endfunction

endpackage

// File: rtl/trng_word_arbiter_if.sv
// Requester and TRNG-core signals of the word arbiter; master is the arbiter
// side, slave is the environment (consumers plus TRNG core).
interface trng_word_arbiter_if #(
  parameter int WORD_W  = 16,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] REQ;
  logic [NUM_REQ-1:0] GNT;
  logic [WORD_W-1:0]  WORD;
  logic [NUM_REQ-1:0] WORD_VALID;
  logic               BUSY;
  logic               TRNG_EN;
  logic               TRNG_BIT;
  logic               TRNG_READY;
  logic               TRNG_ACK;
  logic               HEALTH_FAIL;

  modport master (
    input  REQ, TRNG_BIT, TRNG_READY,
    output GNT, WORD, WORD_VALID, BUSY, TRNG_EN, TRNG_ACK, HEALTH_FAIL
  );

  modport slave (
    output REQ, TRNG_BIT, TRNG_READY,
    input  GNT, WORD, WORD_VALID, BUSY, TRNG_EN, TRNG_ACK, HEALTH_FAIL
  );
endinterface

// File: rtl/trng_word_arbiter_sync.sv
// N-flop synchronizer for the asynchronous TRNG ready line, cleared by a
// synchronous reset.
module trng_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/trng_word_arbiter.sv
// Round-robin word arbiter over a 4-phase TRNG bit handshake.
// Optional repetition-count health test: define TRNG_REPCOUNT_TEST_EN.
module trng_word_arbiter
  import trng_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int NUM_REQ     = 2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int REP_LIMIT   = 8
) (
  input  logic                CLK,
  input  logic                RST,
  trng_word_arbiter_if.master bus
);
  localparam int CW = $clog2(WORD_W + 1);
  localparam int DW = $clog2(SYNC_STAGES + 1);

  trng_arb_state_t    state_q;
  logic [NUM_REQ-1:0] gnt_q, vld_q;
  logic [WORD_W-1:0]  word_q;
  logic [CW-1:0]      cnt_q;
  logic [DW-1:0]      drain_q;
  logic [1:0]         last_q, gidx_q, gidx_d;
  logic [3:0]         req4, gnt4;
  logic               busy_q, en_q, ack_q, rdy_s, discard_d;

  trng_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i(CLK), .rst_i(RST), .d_i(bus.TRNG_READY), .q_o(rdy_s)
  );

  always_comb begin
    req4               = '0;
    req4[NUM_REQ-1:0]  = bus.REQ;
    gnt4               = rr_next(req4, last_q, NUM_REQ);
    gidx_d             = '0;
    for (int i = 0; i < 4; i++) if (gnt4[i]) gidx_d = 2'(i);
  end

`ifdef TRNG_REPCOUNT_TEST_EN
  localparam int RW = $clog2(REP_LIMIT + 1);
  logic [RW-1:0] run_q, run_d;
  logic          run_bit_q, hfail_q;

  always_comb begin
    run_d     = (run_q != '0 && bus.TRNG_BIT == run_bit_q) ? run_q + 1'b1 : RW'(1);
    discard_d = (run_d >= RW'(REP_LIMIT));
  end

  // Run restarts after a discard so the fresh word gets a clean test.
  always_ff @(posedge CLK) begin
    if (RST) begin
      run_q     <= '0;
      run_bit_q <= 1'b0;
      hfail_q   <= 1'b0;
    end else if (state_q == GRANT) begin
      run_q <= '0;
    end else if (state_q == WAIT_RDY && rdy_s) begin
      run_q     <= discard_d ? '0 : run_d;
      run_bit_q <= bus.TRNG_BIT;
      if (discard_d) hfail_q <= 1'b1;
    end
  end

  assign bus.HEALTH_FAIL = hfail_q;
`else
  assign discard_d       = 1'b0;
  assign bus.HEALTH_FAIL = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= DRAIN;
      gnt_q   <= '0;
      vld_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      last_q  <= 2'(NUM_REQ - 1);
      gidx_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      vld_q  <= '0;
      busy_q <= 1'b1;
      unique case (state_q)
        // The synchronizer restarts empty, so give it time to refill before
        // trusting a low rdy_s as "no bit pending".
        DRAIN: begin
          if (drain_q != DW'(SYNC_STAGES)) drain_q <= drain_q + 1'b1;
          else if (!rdy_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (|bus.REQ) begin
            state_q <= GRANT;
            gnt_q   <= gnt4[NUM_REQ-1:0];
            gidx_q  <= gidx_d;
            en_q    <= 1'b1;
            cnt_q   <= '0;
            word_q  <= '0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        GRANT: state_q <= WAIT_RDY;
        WAIT_RDY: begin
          if (rdy_s) begin
            ack_q   <= 1'b1;
            state_q <= ACK_HI;
            if (discard_d) begin
              cnt_q  <= '0;
              word_q <= '0;
            end else begin
              word_q <= word_q | (WORD_W'(bus.TRNG_BIT) << cnt_q);
              cnt_q  <= cnt_q + 1'b1;
            end
          end
        end
        ACK_HI: begin
          if (!rdy_s) begin
            ack_q <= 1'b0;
            if (cnt_q == CW'(WORD_W)) begin
              state_q <= DONE;
              vld_q   <= gnt_q;
              en_q    <= 1'b0;
            end else begin
              state_q <= WAIT_RDY;
            end
          end
        end
        DONE: begin
          gnt_q   <= '0;
          last_q  <= gidx_q;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= DRAIN;
      endcase
    end
  end

  assign bus.GNT        = gnt_q;
  assign bus.WORD       = word_q;
  assign bus.WORD_VALID = vld_q;
  assign bus.BUSY       = busy_q;
  assign bus.TRNG_EN    = en_q;
  assign bus.TRNG_ACK   = ack_q;
endmodule

// File: tb/tb_trng_word_arbiter.sv
// Directed bench for trng_word_arbiter: a TRNG handshake driver, a word/grant
// model built from the delivered bits and round-robin rule, and a cycle checker.
module tb_trng_word_arbiter;
  localparam int WW = 16;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  trng_word_arbiter_if #(.WORD_W(WW), .NUM_REQ(NR)) bus ();

  trng_word_arbiter #(.WORD_W(WW), .NUM_REQ(NR), .SYNC_STAGES(2), .REP_LIMIT(8)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // model state
  logic [WW-1:0] acc;
  int            acc_n, run_n;
  logic          run_b, exp_health;
  logic [WW-1:0] exp_words[$];
  logic [NR-1:0] gnt_log[$];
  int            vcount = 0;
  logic [WW-1:0] last_vw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.TRNG_ACK;
      1:       return bus.BUSY;
      default: return bus.TRNG_EN;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input string nm);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sig(sel) == val) return;
    end
    errors++;
    checks++;
    $display("FAIL %s: timeout, still not %0d", nm, val);
  endtask

  function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return NR'(1 << ((last + k) % NR));
    return '0;
  endfunction

  // A bit counts as taken by the arbiter once ACK rises for it.
  task automatic accept(input logic b);
    acc[acc_n] = b;
    acc_n++;
`ifdef TRNG_REPCOUNT_TEST_EN
    if (run_n > 0 && b == run_b) run_n++;
    else run_n = 1;
    run_b = b;
    if (run_n >= 8) begin
      acc = '0; acc_n = 0; run_n = 0; exp_health = 1'b1;
    end
`endif
    if (acc_n == WW) begin
      exp_words.push_back(acc);
      acc = '0; acc_n = 0; run_n = 0;
    end
  endtask

  task automatic model_reset();
    acc = '0; acc_n = 0; run_n = 0; run_b = 1'b0;
  endtask

  task automatic send_bits(input logic [WW-1:0] pat, input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      wait_for(2, 1'b1, "en_wait");
      bus.TRNG_BIT   = pat[i];
      bus.TRNG_READY = 1'b1;
      wait_for(0, 1'b1, "ack_rise");
      accept(pat[i]);
      if (i == drop_at) bus.REQ = '0;
      bus.TRNG_READY = 1'b0;
      wait_for(0, 1'b0, "ack_fall");
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_gnt"},   bus.GNT, 0);
    chk({nm, "_word"},  bus.WORD, 0);
    chk({nm, "_valid"}, bus.WORD_VALID, 0);
    chk({nm, "_busy"},  bus.BUSY, 0);
    chk({nm, "_en"},    bus.TRNG_EN, 0);
    chk({nm, "_ack"},   bus.TRNG_ACK, 0);
    chk({nm, "_hf"},    bus.HEALTH_FAIL, 0);
  endtask

  // cycle checker against the model
  logic [NR-1:0] req_prev = '0, gnt_prev = '0, cur_g = '0;
  int            m_last = NR - 1;

  always @(negedge clk) begin
    if (rst) begin
      m_last   = NR - 1;
      gnt_prev = '0;
      cur_g    = '0;
    end else begin
      if (gnt_prev == '0 && bus.GNT != '0) begin
        cur_g = rr_pick(req_prev, m_last);
        chk("grant_owner", bus.GNT, cur_g);
        gnt_log.push_back(bus.GNT);
      end
      if (bus.WORD_VALID != '0) begin
        chk("valid_owner", bus.WORD_VALID, cur_g);
        chk("valid_gnt", bus.GNT, cur_g);
        if (exp_words.size() == 0) chk("valid_unexpected", bus.WORD_VALID, 0);
        else chk("word", bus.WORD, exp_words.pop_front());
        vcount++;
        last_vw = bus.WORD;
        for (int i = 0; i < NR; i++) if (cur_g[i]) m_last = i;
      end
      chk("health", bus.HEALTH_FAIL, exp_health);
      gnt_prev = bus.GNT;
    end
    req_prev = bus.REQ;
  end

  initial begin
    int v0, g0;
    bus.REQ = '0; bus.TRNG_BIT = 1'b0; bus.TRNG_READY = 1'b1;
    exp_health = 1'b0; rst = 1'b1;
    model_reset();

    // reset with a bit pending, then drain
    repeat (3) @(posedge clk);
    #1 check_zero("rst");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("drain_ack", bus.TRNG_ACK, 0);
    chk("drain_busy", bus.BUSY, 1);
    bus.TRNG_READY = 1'b0;
    wait_for(1, 1'b0, "drain_exit");

    // single word 0xB00D to requester 0
    v0 = vcount;
    @(posedge clk); #1 bus.REQ = 2'b01;
    @(posedge clk); @(negedge clk);
    chk("gnt_latency", bus.GNT, 2'b01);
    send_bits(16'hB00D, 16, 15);
    wait_for(1, 1'b0, "idle_b00d");
    chk("b00d_count", vcount - v0, 1);
    chk("b00d_word", last_vw, 16'hB00D);
    chk("gnt_cleared", bus.GNT, 0);

    // fresh pointer, both requesting for four words
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_for(1, 1'b0, "rst2_idle");
    v0 = vcount;
    g0 = gnt_log.size();
    @(posedge clk); #1 bus.REQ = 2'b11;
    send_bits(16'h1234, 16, -1);
    send_bits(16'hC3A5, 16, -1);
    send_bits(16'h6E91, 16, -1);
    send_bits(16'h5AF0, 16, 15);
    wait_for(1, 1'b0, "rr_idle");
    chk("rr_count", vcount - v0, 4);
    chk("rr_ngrants", gnt_log.size() - g0, 4);
    if (gnt_log.size() - g0 == 4) begin
      chk("rr_g0", gnt_log[g0],     2'b01);
      chk("rr_g1", gnt_log[g0 + 1], 2'b10);
      chk("rr_g2", gnt_log[g0 + 2], 2'b01);
      chk("rr_g3", gnt_log[g0 + 3], 2'b10);
    end
    chk("rr_last_word", last_vw, 16'h5AF0);

    // reset while ACK is high on the 7th bit
    v0 = vcount;
    @(posedge clk); #1 bus.REQ = 2'b01;
    send_bits(16'h0055, 6, -1);
    wait_for(2, 1'b1, "en_mid");
    bus.TRNG_BIT = 1'b1; bus.TRNG_READY = 1'b1;
    wait_for(0, 1'b1, "ack_mid");
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("midrst");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("mid_drain_ack", bus.TRNG_ACK, 0);
    chk("mid_drain_busy", bus.BUSY, 1);
    bus.TRNG_READY = 1'b0;
    send_bits(16'h9C3B, 16, 15);
    wait_for(1, 1'b0, "mid_idle");
    chk("mid_count", vcount - v0, 1);
    chk("mid_word", last_vw, 16'h9C3B);

    // requester drops after 3 bits
    v0 = vcount;
    @(posedge clk); #1 bus.REQ = 2'b01;
    send_bits(16'h7E81, 16, 2);
    wait_for(1, 1'b0, "drop_idle");
    chk("drop_count", vcount - v0, 1);
    chk("drop_word", last_vw, 16'h7E81);

    // eight ones in a row
    v0 = vcount;
    @(posedge clk); #1 bus.REQ = 2'b01;
`ifdef TRNG_REPCOUNT_TEST_EN
    send_bits(16'h00FF, 8, -1);
    chk("hf_set", bus.HEALTH_FAIL, 1);
    send_bits(16'hAAAA, 16, 15);
    wait_for(1, 1'b0, "hf_idle");
    chk("hf_word", last_vw, 16'hAAAA);
    chk("hf_sticky", bus.HEALTH_FAIL, 1);
    rst = 1'b1;
    exp_health = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("hf_cleared", bus.HEALTH_FAIL, 0);
    rst = 1'b0;
`else
    send_bits(16'h00FF, 16, 15);
    wait_for(1, 1'b0, "hf_idle");
    chk("hf_word", last_vw, 16'h00FF);
    chk("hf_off", bus.HEALTH_FAIL, 0);
`endif
    chk("hf_count", vcount - v0, 1);

    repeat (4) @(posedge clk);
    #1 chk("no_pending", exp_words.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
